// File: rtl/pipeline_pkg.sv
// Shared definitions for the RV32IM pipeline hazard logic: opcode and funct7
// constants plus the divider-tracking FSM state type.
package pipeline_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    typedef enum logic {
        MduIdle,
        MduBusy
    } mdu_state_e;

endpackage

// File: rtl/pipeline_hazard_unit_src_decode.sv
// Decodes which register sources the ID-stage instruction actually reads, and
// whether it is a divider-class (DIV/DIVU/REM/REMU) operation.
module hazard_src_decode
    import pipeline_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [6:0] funct7,
    input  logic [2:0] funct3,
    output logic       use_rs1,
    output logic       use_rs2,
    output logic       is_div
);

    // Source-use and divider-class decode
    always_comb begin
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        is_div  = 1'b0;
        unique case (opcode)
            OP_R: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                if (funct7 == F7_MULDIV) begin
                    // funct3[2] set selects the multi-cycle divide/remainder group
                    unique case (funct3)
                        3'b100, 3'b101, 3'b110, 3'b111: is_div = 1'b1;
                        default:                        is_div = 1'b0;
                    endcase
                end
            end
            OP_IMM, OP_LOAD, OP_JALR: use_rs1 = 1'b1;
            OP_STORE, OP_BRANCH: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/pipeline_hazard_unit.sv
// Hazard and flush controller sitting between ID and EX. Detects load-use
// hazards over a configurable load latency, tracks the long-latency divider,
// gives flushes priority over stalls and keeps saturating event counters.
module pipeline_hazard_unit
    import pipeline_pkg::*;
#(
    parameter int unsigned LOAD_LAT = 1,
    parameter int unsigned MDU_LAT  = 32,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [6:0]       id_opcode,
    input  logic [6:0]       id_funct7,
    input  logic [2:0]       id_funct3,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_ex_valid,
    input  logic             id_ex_mem_read,
    input  logic             id_ex_div,
    input  logic             id_ex_jal,
    input  logic             id_ex_jalr,
    input  logic [4:0]       id_ex_rd,
    input  logic             bpu_correct,
    output logic             load_use_stall,
    output logic             mdu_stall,
    output logic             flush_branch,
    output logic             flush_jal,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic             mdu_busy,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int unsigned        MduCntW = $clog2(MDU_LAT + 1);
    localparam logic [MduCntW-1:0] MduLoad = MduCntW'(MDU_LAT);
    // Each scoreboard entry is {valid, rd}
    localparam int unsigned        EntW    = 6;

    logic use_rs1, use_rs2, id_is_div;

    hazard_src_decode u_src_decode (
        .opcode  (id_opcode),
        .funct7  (id_funct7),
        .funct3  (id_funct3),
        .use_rs1 (use_rs1),
        .use_rs2 (use_rs2),
        .is_div  (id_is_div)
    );

    // ---------------- load scoreboard ----------------
    logic [EntW-1:0]          ld0;
    logic [LOAD_LAT*EntW-1:0] ld_all;
    logic                     load_hazard;

    assign ld0 = {id_ex_valid & id_ex_mem_read & (id_ex_rd != 5'd0), id_ex_rd};

    if (LOAD_LAT > 1) begin : g_hist
        logic [(LOAD_LAT-1)*EntW-1:0] hist_q;

        // Age in-flight loads one slot per cycle; stalls do not freeze this
        always_ff @(posedge clk) begin
            if (rst) begin
                hist_q <= '0;
            end else begin
                hist_q[EntW-1:0] <= ld0;
                for (int k = 1; k < int'(LOAD_LAT) - 1; k++) begin
                    hist_q[k*EntW +: EntW] <= hist_q[(k-1)*EntW +: EntW];
                end
            end
        end

        assign ld_all = {hist_q, ld0};
    end else begin : g_no_hist
        assign ld_all = ld0;
    end

    // Match used ID sources against every valid scoreboard slot
    always_comb begin
        load_hazard = 1'b0;
        for (int k = 0; k < int'(LOAD_LAT); k++) begin
            if (ld_all[k*EntW + 5] &&
                ((use_rs1 && (id_rs1 == ld_all[k*EntW +: 5])) ||
                 (use_rs2 && (id_rs2 == ld_all[k*EntW +: 5])))) begin
                load_hazard = 1'b1;
            end
        end
        load_hazard = load_hazard & id_valid;
    end

    // ---------------- divider busy FSM ----------------
    mdu_state_e         state_q, state_d;
    logic [MduCntW-1:0] cnt_q, cnt_d;
    logic [4:0]         mdu_rd_q, mdu_rd_d;
    logic               div_in_ex;

    assign div_in_ex = id_ex_valid & id_ex_div;

    // FSM, countdown and destination registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= MduIdle;
            cnt_q    <= '0;
            mdu_rd_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mdu_rd_q <= mdu_rd_d;
        end
    end

    // Next-state: load countdown on a divide leaving EX, release at cnt==1
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mdu_rd_d = mdu_rd_q;
        unique case (state_q)
            MduIdle: begin
                if (div_in_ex) begin
                    state_d  = MduBusy;
                    cnt_d    = MduLoad;
                    mdu_rd_d = id_ex_rd;
                end
            end
            MduBusy: begin
                if (div_in_ex) begin
                    cnt_d    = MduLoad;
                    mdu_rd_d = id_ex_rd;
                end else if (cnt_q == MduCntW'(1)) begin
                    state_d = MduIdle;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - MduCntW'(1);
                end
            end
        endcase
    end

    // The structural stall should keep a second divide out of EX while busy
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(state_q == MduBusy && div_in_ex));
        end
    end

    logic mdu_dep, mdu_struct;

    assign mdu_busy   = (state_q == MduBusy);
    assign mdu_dep    = mdu_busy & id_valid & (mdu_rd_q != 5'd0) &
                        ((use_rs1 & (id_rs1 == mdu_rd_q)) | (use_rs2 & (id_rs2 == mdu_rd_q)));
    assign mdu_struct = mdu_busy & id_valid & id_is_div;

    // ---------------- flush / stall priority ----------------
    logic flush_any;

    assign flush_branch   = ~bpu_correct;
    assign flush_jal      = id_ex_valid & (id_ex_jal | id_ex_jalr);
    assign flush_any      = flush_branch | flush_jal;
    assign flush_if_id    = flush_any;
    assign flush_id_ex    = flush_any;
    assign load_use_stall = load_hazard & ~flush_any;
    assign mdu_stall      = (mdu_dep | mdu_struct) & ~flush_any;

    // ---------------- saturating counters ----------------
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    // Increment on an event unless already at all-ones
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if ((load_use_stall | mdu_stall) && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (flush_any && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    // Counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// Scoreboard bench: two instances (LOAD_LAT=1 and LOAD_LAT=3 with 2-bit
// counters), both with MDU_LAT=4, fed identical directed vectors.
module tb_pipeline_hazard_unit;
    import pipeline_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, id_valid, id_ex_valid, id_ex_mem_read, id_ex_div;
    logic       id_ex_jal, id_ex_jalr, bpu_correct;
    logic [6:0] id_opcode, id_funct7;
    logic [2:0] id_funct3;
    logic [4:0] id_rs1, id_rs2, id_ex_rd;

    logic        lu1, mdu1, fb1, fj1, fif1, fidex1, busy1;
    logic [31:0] scnt1, fcnt1;
    logic        lu3, mdu3, fb3, fj3, fif3, fidex3, busy3;
    logic [1:0]  scnt3, fcnt3;

    pipeline_hazard_unit #(.LOAD_LAT(1), .MDU_LAT(4), .CNT_W(32)) u_dut1 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode),
        .id_funct7(id_funct7), .id_funct3(id_funct3), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_ex_valid(id_ex_valid), .id_ex_mem_read(id_ex_mem_read), .id_ex_div(id_ex_div),
        .id_ex_jal(id_ex_jal), .id_ex_jalr(id_ex_jalr), .id_ex_rd(id_ex_rd),
        .bpu_correct(bpu_correct), .load_use_stall(lu1), .mdu_stall(mdu1),
        .flush_branch(fb1), .flush_jal(fj1), .flush_if_id(fif1), .flush_id_ex(fidex1),
        .mdu_busy(busy1), .stall_cnt(scnt1), .flush_cnt(fcnt1)
    );

    pipeline_hazard_unit #(.LOAD_LAT(3), .MDU_LAT(4), .CNT_W(2)) u_dut3 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode),
        .id_funct7(id_funct7), .id_funct3(id_funct3), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_ex_valid(id_ex_valid), .id_ex_mem_read(id_ex_mem_read), .id_ex_div(id_ex_div),
        .id_ex_jal(id_ex_jal), .id_ex_jalr(id_ex_jalr), .id_ex_rd(id_ex_rd),
        .bpu_correct(bpu_correct), .load_use_stall(lu3), .mdu_stall(mdu3),
        .flush_branch(fb3), .flush_jal(fj3), .flush_if_id(fif3), .flush_id_ex(fidex3),
        .mdu_busy(busy3), .stall_cnt(scnt3), .flush_cnt(fcnt3)
    );

    typedef struct {
        string      name;
        logic       rst, id_valid, ex_valid, mem_read, div, jal, jalr, bpu;
        logic [6:0] op, f7;
        logic [2:0] f3;
        logic [4:0] rs1, rs2, ex_rd;
        logic       e_lu1, e_lu3, e_mdu, e_fb, e_fj, e_busy;
        int         e_s1, e_f1, e_s3, e_f3;  // -1 on the LOAD_LAT=3 counters = not checked
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endfunction

    function automatic vec_t base(string name);
        vec_t v;
        v.name = name; v.rst = 1'b0; v.id_valid = 1'b0; v.ex_valid = 1'b0;
        v.mem_read = 1'b0; v.div = 1'b0; v.jal = 1'b0; v.jalr = 1'b0; v.bpu = 1'b1;
        v.op = 7'd0; v.f7 = 7'd0; v.f3 = 3'd0; v.rs1 = 5'd0; v.rs2 = 5'd0; v.ex_rd = 5'd0;
        v.e_lu1 = 1'b0; v.e_lu3 = 1'b0; v.e_mdu = 1'b0; v.e_fb = 1'b0; v.e_fj = 1'b0;
        v.e_busy = 1'b0; v.e_s1 = 0; v.e_f1 = 0; v.e_s3 = -1; v.e_f3 = -1;
        return v;
    endfunction

    function automatic vec_t id_i(vec_t vi, logic [6:0] op, logic [6:0] f7, logic [2:0] f3,
                                  logic [4:0] rs1, logic [4:0] rs2);
        vec_t v = vi;
        v.id_valid = 1'b1; v.op = op; v.f7 = f7; v.f3 = f3; v.rs1 = rs1; v.rs2 = rs2;
        return v;
    endfunction

    function automatic vec_t ex_i(vec_t vi, logic ld, logic dv, logic j, logic jr,
                                  logic [4:0] rd);
        vec_t v = vi;
        v.ex_valid = 1'b1; v.mem_read = ld; v.div = dv; v.jal = j; v.jalr = jr; v.ex_rd = rd;
        return v;
    endfunction

    function automatic vec_t ex_o(vec_t vi, logic lu1e, logic lu3e, logic mdue, logic fbe,
                                  logic fje, logic busye, int s1, int f1);
        vec_t v = vi;
        v.e_lu1 = lu1e; v.e_lu3 = lu3e; v.e_mdu = mdue; v.e_fb = fbe; v.e_fj = fje;
        v.e_busy = busye; v.e_s1 = s1; v.e_f1 = f1;
        return v;
    endfunction

    task automatic add(input vec_t v);
        vecs.push_back(v);
    endtask

    task automatic build();
        vec_t v;
        // reset, with and without an active mispredict
        v = base("rst0"); v.rst = 1'b1; add(v);
        v = base("rst_flush"); v.rst = 1'b1; v.bpu = 1'b0; v.e_fb = 1'b1; add(v);
        v = base("idle"); v.e_s3 = 0; add(v);
        // lw x5 in EX, add x6,x5,x1 held in ID
        v = ex_o(ex_i(id_i(base("lw_add"), OP_R, 7'h00, 3'd0, 5, 1), 1, 0, 0, 0, 5),
                 1, 1, 0, 0, 0, 0, 0, 0); add(v);
        v = ex_o(id_i(base("lw_add_a1"), OP_R, 7'h00, 3'd0, 5, 1), 0, 1, 0, 0, 0, 0, 1, 0);
        add(v);
        v = ex_o(id_i(base("lw_add_a2"), OP_R, 7'h00, 3'd0, 5, 1), 0, 1, 0, 0, 0, 0, 1, 0);
        add(v);
        v = ex_o(id_i(base("lw_add_a3"), OP_R, 7'h00, 3'd0, 5, 1), 0, 0, 0, 0, 0, 0, 1, 0);
        v.e_s3 = 3; add(v);
        // lw x7, addi (rs2 field=7 ignored), lui (rs1 field=7 ignored), sw using x7
        v = ex_o(ex_i(id_i(base("lw7_addi"), OP_IMM, 7'h00, 3'd0, 1, 7), 1, 0, 0, 0, 7),
                 0, 0, 0, 0, 0, 0, 1, 0); add(v);
        v = ex_o(ex_i(id_i(base("lw7_lui"), 7'b0110111, 7'h00, 3'd0, 7, 7), 0, 0, 0, 0, 8),
                 0, 0, 0, 0, 0, 0, 1, 0); add(v);
        v = ex_o(ex_i(id_i(base("lw7_sw"), OP_STORE, 7'h00, 3'b010, 2, 7), 0, 0, 0, 0, 9),
                 0, 1, 0, 0, 0, 0, 1, 0); add(v);
        v = ex_o(id_i(base("lw7_sw_aged"), OP_STORE, 7'h00, 3'b010, 2, 7),
                 0, 0, 0, 0, 0, 0, 1, 0); v.e_s3 = 3; add(v);
        // load to x0 never matches
        v = ex_o(ex_i(id_i(base("lw_x0"), OP_R, 7'h00, 3'd0, 0, 0), 1, 0, 0, 0, 0),
                 0, 0, 0, 0, 0, 0, 1, 0); add(v);
        // div x9 then dependent sub x10,x9,x2
        v = ex_o(ex_i(base("div9"), 0, 1, 0, 0, 9), 0, 0, 0, 0, 0, 0, 1, 0); add(v);
        for (int i = 0; i < 4; i++) begin
            v = ex_o(id_i(base($sformatf("sub_dep%0d", i)), OP_R, 7'h20, 3'd0, 9, 2),
                     0, 0, 1, 0, 0, 1, 1 + i, 0);
            add(v);
        end
        v = ex_o(id_i(base("sub_free"), OP_R, 7'h20, 3'd0, 9, 2), 0, 0, 0, 0, 0, 0, 5, 0);
        v.e_s3 = 3; add(v);
        // div x12, then mul (no stall) and independent rem (structural stall)
        v = ex_o(ex_i(base("div12"), 0, 1, 0, 0, 12), 0, 0, 0, 0, 0, 0, 5, 0); add(v);
        v = ex_o(id_i(base("mul_busy"), OP_R, F7_MULDIV, 3'b000, 4, 5), 0, 0, 0, 0, 0, 1, 5, 0);
        add(v);
        for (int i = 0; i < 3; i++) begin
            v = ex_o(id_i(base($sformatf("rem_struct%0d", i)), OP_R, F7_MULDIV, 3'b110, 4, 5),
                     0, 0, 1, 0, 0, 1, 5 + i, 0);
            add(v);
        end
        v = ex_o(id_i(base("rem_free"), OP_R, F7_MULDIV, 3'b110, 4, 5), 0, 0, 0, 0, 0, 0, 8, 0);
        add(v);
        // lw x5 with mispredict and dependent ID: flush wins
        v = ex_o(ex_i(id_i(base("flush_vs_lu"), OP_R, 7'h00, 3'd0, 5, 1), 1, 0, 0, 0, 5),
                 0, 0, 0, 1, 0, 0, 8, 0); v.bpu = 1'b0; add(v);
        v = ex_o(base("after_flush"), 0, 0, 0, 0, 0, 0, 8, 1); add(v);
        v = ex_o(ex_i(base("jal"), 0, 0, 1, 0, 1), 0, 0, 0, 0, 1, 0, 8, 1); add(v);
        v = ex_o(ex_i(base("jalr_invalid"), 0, 0, 0, 1, 1), 0, 0, 0, 0, 0, 0, 8, 2);
        v.ex_valid = 1'b0; add(v);
        // div x13, dependent sub, flush suppresses stall, then reset mid-busy
        v = ex_o(ex_i(base("div13"), 0, 1, 0, 0, 13), 0, 0, 0, 0, 0, 0, 8, 2); add(v);
        v = ex_o(id_i(base("sub13"), OP_R, 7'h20, 3'd0, 13, 2), 0, 0, 1, 0, 0, 1, 8, 2); add(v);
        v = ex_o(id_i(base("sub13_flush"), OP_R, 7'h20, 3'd0, 13, 2), 0, 0, 0, 1, 0, 1, 9, 2);
        v.bpu = 1'b0; add(v);
        v = ex_o(id_i(base("sub13_rst"), OP_R, 7'h20, 3'd0, 13, 2), 0, 0, 1, 0, 0, 1, 9, 3);
        v.rst = 1'b1; v.e_f3 = 3; add(v);
        v = ex_o(id_i(base("post_rst"), OP_R, 7'h20, 3'd0, 13, 2), 0, 0, 0, 0, 0, 0, 0, 0);
        v.e_s3 = 0; v.e_f3 = 0; add(v);
        v = ex_o(base("post_rst_idle"), 0, 0, 0, 0, 0, 0, 0, 0); add(v);
    endtask

    task automatic apply(input vec_t v);
        rst = v.rst; id_valid = v.id_valid; id_opcode = v.op; id_funct7 = v.f7;
        id_funct3 = v.f3; id_rs1 = v.rs1; id_rs2 = v.rs2; id_ex_valid = v.ex_valid;
        id_ex_mem_read = v.mem_read; id_ex_div = v.div; id_ex_jal = v.jal;
        id_ex_jalr = v.jalr; id_ex_rd = v.ex_rd; bpu_correct = v.bpu;
    endtask

    // Driver: one vector per cycle, expected record pushed to the scoreboard
    initial begin
        vec_t idle_v;
        idle_v = base("init");
        idle_v.rst = 1'b1;
        apply(idle_v);
        build();
        foreach (vecs[i]) begin
            @(posedge clk);
            #1;
            apply(vecs[i]);
            sb.push_back(vecs[i]);
        end
        @(posedge clk);
        #1;
        idle_v.rst = 1'b0;
        apply(idle_v);
        repeat (2) @(posedge clk);
        chk("scoreboard_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Monitor: outputs are valid every cycle; compare mid-cycle
    always @(negedge clk) begin
        vec_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({e.name, ".lu1"}, lu1, e.e_lu1);
            chk({e.name, ".lu3"}, lu3, e.e_lu3);
            chk({e.name, ".mdu_stall"}, mdu1, e.e_mdu);
            chk({e.name, ".mdu_stall3"}, mdu3, e.e_mdu);
            chk({e.name, ".flush_branch"}, fb1, e.e_fb);
            chk({e.name, ".flush_jal"}, fj1, e.e_fj);
            chk({e.name, ".flush_if_id"}, fif1, e.e_fb | e.e_fj);
            chk({e.name, ".flush_id_ex"}, fidex1, e.e_fb | e.e_fj);
            chk({e.name, ".flush3"}, {fb3, fj3, fif3, fidex3},
                {e.e_fb, e.e_fj, e.e_fb | e.e_fj, e.e_fb | e.e_fj});
            chk({e.name, ".mdu_busy"}, busy1, e.e_busy);
            chk({e.name, ".mdu_busy3"}, busy3, e.e_busy);
            chk({e.name, ".stall_cnt"}, scnt1, e.e_s1);
            chk({e.name, ".flush_cnt"}, fcnt1, e.e_f1);
            if (e.e_s3 >= 0) chk({e.name, ".stall_cnt3"}, {30'd0, scnt3}, e.e_s3);
            if (e.e_f3 >= 0) chk({e.name, ".flush_cnt3"}, {30'd0, fcnt3}, e.e_f3);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
